mem_arbiter: RTL

Round-robin arbiter sharing one single-port word memory among NUMREQ requesters: instruction fetch, data load/store and debug loader in the default configuration. It sits between the CPU and a unified `memory` instance, which replaces the separate imem/dmem pair. Each requester gets a same-cycle grant and a one-cycle-later read response routed back to it. Fairness comes from a rotating priority pointer.

---
 rtl/mem_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one single-port word memory
// Same-cycle grant, one-cycle-later read response routed back to the winner.
module mem_arbiter #(
  parameter int NUMREQ    = 3,
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 5
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUMREQ-1:0]           req_i,
  input  logic [NUMREQ-1:0]           we_i,
  input  logic [NUMREQ*ADDRWIDTH-1:0] addr_i,
  input  logic [NUMREQ*DATAWIDTH-1:0] wdata_i,
  output logic [NUMREQ-1:0]           gnt_o,
  output logic [NUMREQ-1:0]           rvalid_o,
  output logic [DATAWIDTH-1:0]        rdata_o,
  output logic                        mem_re_o,
  output logic                        mem_we_o,
  output logic [ADDRWIDTH-1:0]        mem_addr_o,
  output logic [DATAWIDTH-1:0]        mem_wdata_o,
  input  logic [DATAWIDTH-1:0]        mem_rdata_i
);

  localparam int PTRW = (NUMREQ > 1) ? $clog2(NUMREQ) : 1;

  logic [PTRW-1:0] ptr_q, ptr_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [PTRW-1:0] rsp_id_q, rsp_id_d;

  logic            found;
  logic            grant;
  logic [PTRW-1:0] win;

  logic [ADDRWIDTH-1:0] addr_arr  [NUMREQ];
  logic [DATAWIDTH-1:0] wdata_arr [NUMREQ];

  for (genvar g = 0; g < NUMREQ; g++) begin : g_unpack
    assign addr_arr[g]  = addr_i[g*ADDRWIDTH +: ADDRWIDTH];
    assign wdata_arr[g] = wdata_i[g*DATAWIDTH +: DATAWIDTH];
  end

  // Two passes: indices at or above ptr first, then the wrapped-around ones below it.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int j = 0; j < NUMREQ; j++) begin
      if (!found && req_i[j[PTRW-1:0]] && (j >= int'(ptr_q))) begin
        found = 1'b1;
        win   = j[PTRW-1:0];
      end
    end
    for (int j = 0; j < NUMREQ; j++) begin
      if (!found && req_i[j[PTRW-1:0]] && (j < int'(ptr_q))) begin
        found = 1'b1;
        win   = j[PTRW-1:0];
      end
    end
  end

  assign grant = found && !rst_i;

  always_comb begin
    gnt_o       = '0;
    mem_re_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (grant) begin
      gnt_o[win]  = 1'b1;
      mem_we_o    = we_i[win];
      mem_re_o    = !we_i[win];
      mem_addr_o  = addr_arr[win];
      mem_wdata_o = wdata_arr[win];
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    if (grant) begin
      ptr_d = (win == PTRW'(NUMREQ - 1)) ? '0 : win + 1'b1;
      if (!we_i[win]) begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = win;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    if (rsp_valid_q) begin
      rvalid_o[rsp_id_q] = 1'b1;
      rdata_o            = mem_rdata_i;
    end
  end

endmodule
